// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display scheduler.
//   - disp_state_e : conversion FSM states
//   - BCD_MAX      : largest displayable value; larger inputs saturate to it
//   - BCD_DIGITS   : digits on the display
//   - SHIFT_STEPS  : double-dabble steps per conversion (one per binary bit)
//   - P_ALL_OFF / P_TEMP : decimal point patterns (1 = point off)
//   - dd_step()       : one double-dabble adjust-and-shift step
//   - lead_zero_en()  : digit enables with leading zeros blanked
package score_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StCommit
  } disp_state_e;

  localparam int unsigned BCD_MAX     = 9999;
  localparam int unsigned BCD_DIGITS  = 4;
  localparam int unsigned SHIFT_STEPS = 16;
  localparam logic [3:0]  P_ALL_OFF   = 4'b1111;
  localparam logic [3:0]  P_TEMP      = 4'b0111;

  // Add 3 to every nibble >= 5, then shift left taking the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic msb);
    logic [15:0] adj;
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
    end
    return {adj[14:0], msb};
  endfunction

  // Digit 0 always lit; a higher digit is lit if it or any digit above it is non-zero.
  function automatic logic [3:0] lead_zero_en(input logic [15:0] bcd);
    logic [3:0] e;
    e[3] = (bcd[15:12] != 4'd0);
    e[2] = e[3] | (bcd[11:8] != 4'd0);
    e[1] = e[2] | (bcd[7:4] != 4'd0);
    e[0] = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dd_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD engine.
//   clk, rst : clock, synchronous active-high reset
//   start    : load value and clear the BCD register (one cycle)
//   value    : binary input, must already be <= 9999
//   done     : high during the final shift step; bcd is final from the next cycle
//   bcd      : 4-digit BCD result register
module dd_bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        done,
  output logic [15:0] bcd
);

  localparam logic [4:0] LastStep = 5'(SHIFT_STEPS - 1);

  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [4:0]  cnt_q;
  logic        active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      bin_q    <= value;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bcd_q <= dd_step(bcd_q, bin_q[15]);
      bin_q <= {bin_q[14:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == LastStep) begin
        active_q <= 1'b0;
      end
    end
  end

  assign done = active_q && (cnt_q == LastStep);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_disp_sched.sv
// Schedules the shared 4-digit display between a background score (source 0) and
// temporary message sources (1..N_SRC-1), converts the shown value to BCD and
// drives the HEXS/EN/P inputs of the digit scanner.
//   clk, rst : clock, synchronous active-high reset
//   src_val  : packed source values, source i at [i*VAL_W +: VAL_W]
//   src_req  : level requests for temporary display (bit 0 ignored)
//   src_ack  : one-cycle grant pulse
//   hexs     : 4-digit BCD, digit 3 at [15:12]
//   en       : digit enables (1 = lit)
//   p        : decimal points (1 = off); leftmost lit while a temporary source shows
//   busy     : conversion in progress
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits;
// otherwise en stays 4'b1111.
module score_disp_sched
  import score_disp_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned VAL_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*VAL_W-1:0] src_val,
  input  logic [N_SRC-1:0]       src_req,
  output logic [N_SRC-1:0]       src_ack,
  output logic [15:0]            hexs,
  output logic [3:0]             en,
  output logic [3:0]             p,
  output logic                   busy
);

  localparam int unsigned SelW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [VAL_W-1:0] SatLim   = VAL_W'(BCD_MAX);
  localparam logic [SelW-1:0]  LastSrc  = SelW'(N_SRC - 1);

  // Arbitration and hold timer
  logic [SelW-1:0]  sel_q, sel_d;
  logic [SelW-1:0]  ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic             gnt_valid;
  logic [SelW-1:0]  gnt_idx;

  // Conversion FSM
  disp_state_e      state_q;
  logic             busy_q;
  logic [15:0]      hexs_q;
  logic [3:0]       en_q;
  logic [3:0]       p_q;
  logic [VAL_W-1:0] last_val_q;
  logic             last_valid_q;
  logic [SelW-1:0]  conv_sel_q;
  logic [VAL_W-1:0] raw_q;

  logic [VAL_W-1:0] cur_val;
  logic [15:0]      sat_val;
  logic             trigger;
  logic             eng_start;
  logic             eng_done;
  logic [15:0]      eng_bcd;
  logic [3:0]       commit_en;

  // Value of the currently selected source.
  always_comb begin
    cur_val = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel_q == SelW'(i)) begin
        cur_val = src_val[i*VAL_W +: VAL_W];
      end
    end
  end

  assign sat_val = (cur_val > SatLim) ? 16'(BCD_MAX) : 16'(cur_val);

  // Round-robin search over sources 1..N_SRC-1 starting at the pointer.
  always_comb begin
    int unsigned idx32;
    logic [SelW-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx32     = 0;
    idx       = '0;
    for (int unsigned i = 0; i < N_SRC - 1; i++) begin
      idx32 = 32'(ptr_q) + i;
      if (idx32 > N_SRC - 1) begin
        idx32 = idx32 - (N_SRC - 1);
      end
      idx = SelW'(idx32);
      if (!gnt_valid && src_req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    ack_d  = '0;
    if ((sel_q != '0) && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end else if (gnt_valid) begin
      sel_d  = gnt_idx;
      hold_d = HoldLoad;
      ptr_d  = (gnt_idx == LastSrc) ? SelW'(1) : gnt_idx + 1'b1;
      ack_d  = N_SRC'(1) << gnt_idx;
    end else begin
      sel_d  = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      ptr_q  <= SelW'(1);
      hold_q <= '0;
      ack_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      ack_q  <= ack_d;
    end
  end

  // Unsaturated value is compared so a steady out-of-range input stays quiet.
  assign trigger = !last_valid_q || (sel_q != conv_sel_q) || (cur_val != last_val_q);

`ifdef LEADING_ZERO_BLANK_EN
  assign commit_en = lead_zero_en(eng_bcd);
`else
  assign commit_en = 4'b1111;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      hexs_q       <= '0;
      en_q         <= 4'b1111;
      p_q          <= P_ALL_OFF;
      last_val_q   <= '0;
      last_valid_q <= 1'b0;
      conv_sel_q   <= '0;
      raw_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          raw_q      <= cur_val;
          conv_sel_q <= sel_q;
          state_q    <= StShift;
        end
        StShift: begin
          if (eng_done) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          hexs_q       <= eng_bcd;
          en_q         <= commit_en;
          p_q          <= (conv_sel_q == '0) ? P_ALL_OFF : P_TEMP;
          last_val_q   <= raw_q;
          last_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign eng_start = (state_q == StLoad);

  dd_bin2bcd_seq u_dd (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .value (sat_val),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  assign src_ack = ack_q;
  assign hexs    = hexs_q;
  assign en      = en_q;
  assign p       = p_q;
  assign busy    = busy_q;

endmodule
